// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU port, the IO port and the single-port data RAM.
// The arbiter takes the slave modport; the requesters and the RAM side take the master modport.
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_wen;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;

  logic        io_req;
  logic        io_wen;
  logic [11:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_gnt;
  logic        io_rvalid;
  logic [31:0] io_rdata;

  logic        mem_wen;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata,
    input  io_req, io_wen, io_addr, io_wdata,
    output io_gnt, io_rvalid, io_rdata,
    output mem_wen, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata,
    output io_req, io_wen, io_addr, io_wdata,
    input  io_gnt, io_rvalid, io_rdata,
    input  mem_wen, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one data RAM: CPU has priority, IO wins after STARVE_LIMIT denied cycles.
// A return-owner FSM routes the registered RAM read data back to whoever issued the read.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clock,
  input logic           reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {NONE, CPU_RD, IO_RD} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_t      state;
  logic [3:0]  starve_cnt;
  logic [31:0] cpu_hold;
  logic        io_rvalid_q;
  logic        starve_hit;
  logic        io_grant;
  logic        cpu_grant;

  // A zero limit makes the starvation test permanently true, i.e. IO always wins.
  assign starve_hit = (LIMIT == 4'd0) || (starve_cnt == LIMIT);
  assign io_grant   = bus.io_req && (!bus.cpu_req || starve_hit);
  assign cpu_grant  = bus.cpu_req && !io_grant;

  always_comb begin
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = 12'h000;
    bus.mem_wdata = 32'h0000_0000;
    if (io_grant) begin
      bus.mem_wen   = bus.io_wen;
      bus.mem_addr  = bus.io_addr;
      bus.mem_wdata = bus.io_wdata;
    end else if (cpu_grant) begin
      bus.mem_wen   = bus.cpu_wen;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  assign bus.io_gnt    = io_grant;
  assign bus.cpu_stall = bus.cpu_req && !cpu_grant;
  assign bus.io_rvalid = io_rvalid_q;
  assign bus.io_rdata  = io_rvalid_q ? bus.mem_rdata : 32'h0000_0000;
  assign bus.cpu_rdata = (state == CPU_RD) ? bus.mem_rdata : cpu_hold;

  // Reset drops any pending read return, so no stale io_rvalid appears after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= NONE;
      io_rvalid_q <= 1'b0;
      starve_cnt  <= 4'd0;
      cpu_hold    <= 32'h0000_0000;
    end else begin
      if (!bus.io_req || io_grant) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      if (io_grant && !bus.io_wen) begin
        state       <= IO_RD;
        io_rvalid_q <= 1'b1;
      end else if (cpu_grant && !bus.cpu_wen) begin
        state       <= CPU_RD;
        io_rvalid_q <= 1'b0;
      end else begin
        state       <= NONE;
        io_rvalid_q <= 1'b0;
      end

      if (state == CPU_RD) begin
        cpu_hold <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for mid-cycle reset, counter clearing and STARVE_LIMIT=0.
module tb_mem_arbiter;

  typedef struct {
    logic        cr;
    logic        cw;
    logic [11:0] ca;
    logic [31:0] cd;
    logic        ir;
    logic        iw;
    logic [11:0] ia;
    logic [31:0] id;
    logic        e_gnt;
    logic        e_stall;
    logic        e_mwen;
    logic [11:0] e_maddr;
    logic [31:0] e_mwdata;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic [31:0] e_cpu_rdata;
  } vec_t;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_fail;
  vec_t vecs[$];
  logic [31:0] ram [4096];

  mem_arbiter_if bus0();
  mem_arbiter_if bus1();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  mem_arbiter #(.STARVE_LIMIT(0)) dut_zero (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-read RAM behind the main arbiter.
  always @(posedge clock) begin
    if (bus0.mem_wen) ram[bus0.mem_addr] <= bus0.mem_wdata;
    bus0.mem_rdata <= ram[bus0.mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic cr, input logic cw, input logic [11:0] ca, input logic [31:0] cd,
                         input logic ir, input logic iw, input logic [11:0] ia, input logic [31:0] id,
                         input logic e_gnt, input logic e_stall, input logic e_mwen,
                         input logic [11:0] e_maddr, input logic [31:0] e_mwdata,
                         input logic e_rvalid, input logic [31:0] e_rdata, input logic [31:0] e_cpu_rdata);
    vec_t v;
    v = '{cr, cw, ca, cd, ir, iw, ia, id, e_gnt, e_stall, e_mwen, e_maddr, e_mwdata,
          e_rvalid, e_rdata, e_cpu_rdata};
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus0.cpu_req   = v.cr;
    bus0.cpu_wen   = v.cw;
    bus0.cpu_addr  = v.ca;
    bus0.cpu_wdata = v.cd;
    bus0.io_req    = v.ir;
    bus0.io_wen    = v.iw;
    bus0.io_addr   = v.ia;
    bus0.io_wdata  = v.id;
  endtask

  task automatic check_output(input int idx, input vec_t v);
    check($sformatf("v%0d io_gnt", idx),    32'(bus0.io_gnt),    32'(v.e_gnt));
    check($sformatf("v%0d cpu_stall", idx), 32'(bus0.cpu_stall), 32'(v.e_stall));
    check($sformatf("v%0d mem_wen", idx),   32'(bus0.mem_wen),   32'(v.e_mwen));
    check($sformatf("v%0d mem_addr", idx),  32'(bus0.mem_addr),  32'(v.e_maddr));
    check($sformatf("v%0d mem_wdata", idx), bus0.mem_wdata,      v.e_mwdata);
  endtask

  task automatic check_return(input int idx, input vec_t v);
    check($sformatf("v%0d io_rvalid", idx), 32'(bus0.io_rvalid), 32'(v.e_rvalid));
    check($sformatf("v%0d io_rdata", idx),  bus0.io_rdata,       v.e_rdata);
    check($sformatf("v%0d cpu_rdata", idx), bus0.cpu_rdata,      v.e_cpu_rdata);
  endtask

  task automatic both_request();
    bus0.cpu_req = 1'b1; bus0.cpu_wen = 1'b0; bus0.cpu_addr = 12'h010; bus0.cpu_wdata = '0;
    bus0.io_req  = 1'b1; bus0.io_wen  = 1'b0; bus0.io_addr  = 12'h020; bus0.io_wdata  = '0;
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    ram[12'h020]   = 32'h1234_5678;
    bus0.mem_rdata = 32'h0;
    bus1.mem_rdata = 32'h0;
    bus1.cpu_req = 1'b0; bus1.cpu_wen = 1'b0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.io_req  = 1'b0; bus1.io_wen  = 1'b0; bus1.io_addr  = '0; bus1.io_wdata  = '0;
    bus0.cpu_req = 1'b0; bus0.cpu_wen = 1'b0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
    bus0.io_req  = 1'b0; bus0.io_wen  = 1'b0; bus0.io_addr  = '0; bus0.io_wdata  = '0;

    // cr cw ca cd | ir iw ia id | gnt stall mwen maddr mwdata | rvalid rdata cpu_rdata
    add_vec(1,1,12'h010,32'hDEAD_BEEF, 0,0,12'h000,32'h0, 0,0,1,12'h010,32'hDEAD_BEEF, 0,32'h0,32'h0);
    add_vec(1,0,12'h010,32'h0,         0,0,12'h000,32'h0, 0,0,0,12'h010,32'h0, 0,32'h0,32'hDEAD_BEEF);
    add_vec(0,0,12'h000,32'h0,         0,0,12'h000,32'h0, 0,0,0,12'h000,32'h0, 0,32'h0,32'hDEAD_BEEF);
    add_vec(0,0,12'h000,32'h0,         1,0,12'h020,32'h0, 1,0,0,12'h020,32'h0, 1,32'h1234_5678,32'hDEAD_BEEF);
    add_vec(0,0,12'h000,32'h0,         1,1,12'h030,32'h5, 1,0,1,12'h030,32'h5, 0,32'h0,32'hDEAD_BEEF);
    add_vec(1,0,12'h030,32'h0,         0,0,12'h000,32'h0, 0,0,0,12'h030,32'h0, 0,32'h0,32'h5);
    add_vec(0,0,12'h000,32'h0,         1,0,12'h020,32'h0, 1,0,0,12'h020,32'h0, 1,32'h1234_5678,32'h5);
    add_vec(0,0,12'h000,32'h0,         1,1,12'h040,32'hA5A5_A5A5, 1,0,1,12'h040,32'hA5A5_A5A5, 0,32'h0,32'h5);
    // Starvation: two full rounds of four denials then one IO grant.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++)
        add_vec(1,0,12'h010,32'h0, 1,0,12'h020,32'h0, 0,0,0,12'h010,32'h0, 0,32'h0,32'hDEAD_BEEF);
      add_vec(1,0,12'h010,32'h0, 1,0,12'h020,32'h0, 1,1,0,12'h020,32'h0, 1,32'h1234_5678,32'hDEAD_BEEF);
    end
    // Dropping io_req part-way clears the count, so a fresh run of four denials follows.
    for (int k = 0; k < 2; k++)
      add_vec(1,0,12'h010,32'h0, 1,0,12'h020,32'h0, 0,0,0,12'h010,32'h0, 0,32'h0,32'hDEAD_BEEF);
    add_vec(1,0,12'h010,32'h0, 0,0,12'h020,32'h0, 0,0,0,12'h010,32'h0, 0,32'h0,32'hDEAD_BEEF);
    for (int k = 0; k < 4; k++)
      add_vec(1,0,12'h010,32'h0, 1,0,12'h020,32'h0, 0,0,0,12'h010,32'h0, 0,32'h0,32'hDEAD_BEEF);
    add_vec(1,0,12'h010,32'h0, 1,0,12'h020,32'h0, 1,1,0,12'h020,32'h0, 1,32'h1234_5678,32'hDEAD_BEEF);

    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("reset io_rvalid", 32'(bus0.io_rvalid), 32'h0);
    check("reset io_rdata",  bus0.io_rdata,       32'h0);
    check("reset cpu_rdata", bus0.cpu_rdata,      32'h0);
    check("reset io_gnt",    32'(bus0.io_gnt),    32'h0);
    check("reset mem_addr",  32'(bus0.mem_addr),  32'h0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      apply_stimulus(vecs[i]);
      #1 check_output(i, vecs[i]);
      @(posedge clock);
      #1 check_return(i, vecs[i]);
    end

    // IO read granted, then reset asserted mid-cycle before the access edge.
    @(negedge clock);
    bus0.cpu_req = 1'b0;
    bus0.io_req = 1'b1; bus0.io_wen = 1'b0; bus0.io_addr = 12'h020;
    #2 reset = 1'b0;
    #1;
    check("rst io_gnt comb", 32'(bus0.io_gnt),  32'h1);
    check("rst cpu_rdata",   bus0.cpu_rdata,    32'h0);
    @(posedge clock);
    #1;
    check("rst io_rvalid",   32'(bus0.io_rvalid), 32'h0);
    check("rst io_rdata",    bus0.io_rdata,       32'h0);
    @(negedge clock);
    bus0.io_req = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("post-rst io_rvalid", 32'(bus0.io_rvalid), 32'h0);
    check("post-rst cpu_rdata", bus0.cpu_rdata,      32'h0);

    // Build starve_cnt to 3, pulse reset mid-cycle, then expect a full four denials.
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      both_request();
    end
    @(negedge clock);
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    #1 check("cnt clr c0 io_gnt", 32'(bus0.io_gnt), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      #1 check($sformatf("cnt clr c%0d io_gnt", k), 32'(bus0.io_gnt), (k == 4) ? 32'h1 : 32'h0);
    end

    // STARVE_LIMIT=0: IO wins every cycle while both request.
    @(negedge clock);
    bus0.cpu_req = 1'b0; bus0.io_req = 1'b0;
    bus1.cpu_req = 1'b1; bus1.cpu_wen = 1'b0; bus1.cpu_addr = 12'h011;
    bus1.io_req  = 1'b1; bus1.io_wen  = 1'b0; bus1.io_addr  = 12'h022;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("lim0 c%0d io_gnt", k),    32'(bus1.io_gnt),    32'h1);
      check($sformatf("lim0 c%0d cpu_stall", k), 32'(bus1.cpu_stall), 32'h1);
      check($sformatf("lim0 c%0d mem_addr", k),  32'(bus1.mem_addr),  32'h022);
      @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
